// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC sequencer: enables, flushes, data-wait FSM, halt drain, watchdog.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int unsigned DWAIT_MAX = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmemREN_me,
    input  logic        dmemWEN_me,
    input  logic        halt_me,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        pc_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exme_en,
    output logic        mewb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exme_flush,
    output logic        mewb_flush,
    output logic        dmem_block,
    output logic        halt_out,
    output logic        mem_timeout,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_br_flush
);

    localparam int unsigned CW = $clog2(DWAIT_MAX + 1);
    localparam logic [CW-1:0] WMAX = CW'(DWAIT_MAX);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MDONE = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;

    logic mem_req, mem_ok, advance, lu_hazard;
    logic take_redirect, take_bubble, take_halt;

    assign mem_req   = dmemREN_me | dmemWEN_me;
    assign mem_ok    = ~mem_req | dhit | (state_q == MDONE);
    // nRST folded in so every strobe and counter update is dead while reset is held
    assign advance   = nRST & ihit & mem_ok & (state_q != HALT);
    assign lu_hazard = idex_memread & (idex_rt != 5'd0) &
                       ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    assign take_redirect = advance & pc_redirect;
    assign take_bubble   = advance & ~pc_redirect & lu_hazard;
    assign take_halt     = advance & halt_me;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (take_halt)
                    state_d = HALT;
                else if (mem_req & dhit & ~advance)
                    state_d = MDONE;
            end
            MDONE: begin
                if (take_halt)
                    state_d = HALT;
                else if (advance)
                    state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wcnt_d = wcnt_q;
        tmo_d  = tmo_q;
        if (~mem_req | dhit) begin
            wcnt_d = '0;
        end else if ((state_q == RUN) && (wcnt_q != WMAX)) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_d == WMAX)
                tmo_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        pc_en      = advance;
        ifid_en    = advance;
        idex_en    = advance;
        exme_en    = advance;
        mewb_en    = advance;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exme_flush = 1'b0;
        mewb_flush = 1'b0;
        if (take_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
        if (take_bubble) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
        // halt drains: only the halt itself retires into MEM/WB
        if (take_halt) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exme_flush = 1'b1;
        end
    end

    assign dmem_block  = nRST & (state_q == MDONE);
    assign halt_out    = nRST & (state_q == HALT);
    assign mem_timeout = tmo_q;

`ifdef PIPE_PERF_EN
    logic [31:0] pmem_q, plu_q, pbr_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pmem_q <= '0;
            plu_q  <= '0;
            pbr_q  <= '0;
        end else begin
            if (!mem_ok && (pmem_q != '1))
                pmem_q <= pmem_q + 32'd1;
            if (take_bubble && (plu_q != '1))
                plu_q <= plu_q + 32'd1;
            if (take_redirect && (pbr_q != '1))
                pbr_q <= pbr_q + 32'd1;
        end
    end

    assign perf_mem_stall = pmem_q;
    assign perf_lu_stall  = plu_q;
    assign perf_br_flush  = pbr_q;
`else
    assign perf_mem_stall = '0;
    assign perf_lu_stall  = '0;
    assign perf_br_flush  = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It generates per-latch enable and flush strobes, handling instruction and data memory wait states, load-use bubbles, taken-branch redirects and halt drain. A small FSM tracks data-memory completion so an access that has already finished is never re-issued while the pipeline is frozen for another reason.

Parameters:
DWAIT_MAX, 255, consecutive data-wait cycles before mem_timeout is set; counter width is clog2(DWAIT_MAX+1).

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmemREN_me  in  1  MEM-stage read request, from the EX/MEM latch
dmemWEN_me  in  1  MEM-stage write request, from the EX/MEM latch
halt_me  in  1  halt instruction in the MEM stage
idex_memread  in  1  ID/EX instruction is a load
idex_rt  in  5  load destination register in ID/EX
ifid_rs  in  5  rs of the instruction in IF/ID
ifid_rt  in  5  rt of the instruction in IF/ID
pc_redirect  in  1  taken branch or jump resolved in EX
pc_en  out  1  PC update enable
ifid_en, idex_en, exme_en, mewb_en  out  1 each  latch enables
ifid_flush, idex_flush, exme_flush, mewb_flush  out  1 each  latch flushes; flush has priority over enable inside the latch
dmem_block  out  1  suppresses re-issue of the MEM-stage access
halt_out  out  1  processor halted, sticky
mem_timeout  out  1  sticky data-wait watchdog flag
perf_mem_stall, perf_lu_stall, perf_br_flush  out  32 each  performance counters

Behaviour:
- Asynchronous reset (nRST = 0): state RUN, wait counter 0, mem_timeout 0, counters 0. While nRST is low, all enables, flushes, dmem_block and halt_out are driven 0.
- mem_req = dmemREN_me | dmemWEN_me.
- mem_ok = !mem_req | dhit | (state == MDONE).
- advance = ihit & mem_ok & (state != HALT).
- FSM states:
  - RUN: if mem_req & dhit & !advance, go to MDONE.
  - MDONE: dmem_block = 1. On advance, go to RUN.
  - HALT: absorbing until reset.
  - From RUN or MDONE, advance & halt_me goes to HALT.
- Enables, all combinational:
  - advance = 0: every enable and every flush is 0 (full freeze).
  - advance = 1: baseline is all enables 1, all flushes 0, then the priority rules below apply.
- Priority 1, redirect (advance & pc_redirect): ifid_flush = 1 and idex_flush = 1; pc_en = 1 so the PC takes the target.
- Priority 2, load-use (advance & !pc_redirect & idex_memread & idex_rt != 0 & (idex_rt == ifid_rs | idex_rt == ifid_rt)): pc_en = 0, ifid_en = 0, idex_flush = 1 (bubble); exme_en and mewb_en stay 1.
- Halt (advance & halt_me): mewb_en = 1 this cycle so the halt retires. pc_en = 0, ifid_en = 0, idex_en = 0, exme_flush = 1.
- HALT state: all enables 0, halt_out = 1 from the cycle after entry.
- Data watchdog:
  - Counter increments on each cycle with mem_req & !dhit & state == RUN.
  - Counter clears on dhit or when mem_req is low.
  - Reaching DWAIT_MAX sets mem_timeout (sticky). The counter saturates.
- Simultaneous redirect and load-use: redirect wins. The load-use pair is squashed, so no bubble and no counter increment.
- dhit and ihit in the same cycle: advance is 1 and the FSM stays in RUN.
- A reset asserted mid-wait or in MDONE aborts to RUN immediately.

Optional Feature:
PIPE_PERF_EN.
- Defined: three 32-bit saturating counters, each incremented on the stated condition.
  - perf_mem_stall: cycles with !mem_ok.
  - perf_lu_stall: cycles with a load-use bubble inserted.
  - perf_br_flush: cycles with a redirect flush issued.
- Not defined: the counters are not built and all three outputs are tied to 0.

Test Plan:
- Reset, then ihit = 1 with no requests: all enables 1, flushes 0, pc_en 1, halt_out 0.
- dmemREN_me = 1, dhit = 0 for 3 cycles, then dhit = 1 with ihit = 1: enables 0 for 3 cycles, then all 1. perf_mem_stall = 3.
- dhit = 1 while ihit = 0, then ihit = 1 two cycles later with dmemREN_me still 1:
  - dmem_block = 1 during the 2-cycle gap (MDONE), enables 0.
  - Then advance, return to RUN, dmem_block = 0.
- idex_memread = 1, idex_rt = 5, ifid_rs = 5, ihit = 1: pc_en = 0, ifid_en = 0, idex_flush = 1, exme_en = 1. Repeat with idex_rt = 0: no stall.
- pc_redirect = 1 together with the load-use condition: ifid_flush = 1, idex_flush = 1, pc_en = 1, perf_lu_stall unchanged.
- halt_me = 1 with ihit = 1: mewb_en = 1, exme_flush = 1 that cycle. Next cycle halt_out = 1 and all enables 0 for 10+ cycles. With DWAIT_MAX = 4 and a stuck dmem request, mem_timeout = 1 after 4 cycles.
